program_memory_loader: RTL and testbench

Parametrised, loadable instruction memory that replaces the fixed, hard-wired program table feeding the microprocessor's `instruction` input. A host streams a program in over a valid/ready port; the processor then fetches by `pc` with a registered, one-cycle read. Out-of-range fetches return a programmable fill word and raise a flag. The block sits between the program source (bench or host loader) and the `Microprocessor` `instruction`/`pc` pins.

---
 rtl/program_memory_loader.sv | 160 ++++++++++++++++
 tb/tb_program_memory_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_memory_loader.sv
// Loadable instruction memory: a host streams a program in over valid/ready,
// and the processor then fetches it by pc with a registered one-cycle read.
module program_memory_loader #(
    parameter int              IW    = 8,
    parameter int              DEPTH = 64,
    parameter int              PCW   = 8,
    parameter logic [IW-1:0]   FILL  = {IW{1'b0}}
) (
    input  logic                         origclk,
    input  logic                         reset,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [IW-1:0]                load_data,
    input  logic                         load_last,
    input  logic                         run_start,
    input  logic                         run_stop,
    input  logic [PCW-1:0]               pc,
    output logic [IW-1:0]                instruction,
    output logic                         instr_valid,
    output logic                         pc_oob,
    output logic [$clog2(DEPTH+1)-1:0]   prog_len,
    output logic                         running
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (PCW > LW) ? PCW : LW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t            state_r;
    logic [AW-1:0]     wr_ptr_r;
    logic [LW-1:0]     prog_len_r;
    logic              load_ready_r;
    logic              running_r;
    logic [IW-1:0]     instruction_r;
    logic              instr_valid_r;
    logic              pc_oob_r;
    logic [IW-1:0]     mem_r [DEPTH];

    logic              xfer_s;
    logic [AW-1:0]     wr_addr_s;
    logic              last_word_s;
    logic [CW-1:0]     pc_ext_s;
    logic [CW-1:0]     len_ext_s;
    logic              in_range_s;
    logic [AW-1:0]     rd_addr_s;

    assign xfer_s     = load_valid && load_ready_r;
    assign pc_ext_s   = CW'(pc);
    assign len_ext_s  = CW'(prog_len_r);
    assign in_range_s = (pc_ext_s < len_ext_s);
    assign rd_addr_s  = pc_ext_s[AW-1:0];

    // Write address: a transfer outside LOAD always starts a fresh program at 0
    always_comb begin
        wr_addr_s   = {AW{1'b0}};
        last_word_s = 1'b0;
        if (state_r == LOAD) begin
            wr_addr_s = wr_ptr_r;
        end else begin
            wr_addr_s = {AW{1'b0}};
        end
        last_word_s = load_last || (wr_addr_s == AW'(DEPTH - 1));
    end

    // Control FSM with registered handshake and status outputs
    always_ff @(posedge origclk) begin
        if (reset) begin
            state_r      <= IDLE;
            wr_ptr_r     <= {AW{1'b0}};
            prog_len_r   <= {LW{1'b0}};
            load_ready_r <= 1'b1;
            running_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE, READY: begin
                    if (xfer_s) begin
                        wr_ptr_r <= AW'(1);
                        if (load_last) begin
                            state_r    <= READY;
                            prog_len_r <= LW'(1);
                        end else begin
                            state_r    <= LOAD;
                            prog_len_r <= {LW{1'b0}};
                        end
                    end else if ((state_r == READY) && run_start) begin
                        state_r      <= RUN;
                        load_ready_r <= 1'b0;
                        running_r    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (xfer_s) begin
                        wr_ptr_r <= wr_ptr_r + AW'(1);
                        if (last_word_s) begin
                            state_r    <= READY;
                            prog_len_r <= LW'(wr_ptr_r) + LW'(1);
                        end
                    end
                end
                RUN: begin
                    // Stop takes priority over a simultaneous start
                    if (run_stop) begin
                        state_r      <= READY;
                        load_ready_r <= 1'b1;
                        running_r    <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    load_ready_r <= 1'b1;
                    running_r    <= 1'b0;
                end
            endcase
        end
    end

    // Program storage; deliberately unreset, old contents hidden by prog_len
    always_ff @(posedge origclk) begin
        if (xfer_s && !reset) begin
            mem_r[wr_addr_s] <= load_data;
        end
    end

    // Registered fetch path, active only while running
    always_ff @(posedge origclk) begin
        if (reset) begin
            instruction_r <= FILL;
            instr_valid_r <= 1'b0;
            pc_oob_r      <= 1'b0;
        end else if (state_r == RUN) begin
            instr_valid_r <= 1'b1;
            if (in_range_s) begin
                instruction_r <= mem_r[rd_addr_s];
                pc_oob_r      <= 1'b0;
            end else begin
                instruction_r <= FILL;
                pc_oob_r      <= 1'b1;
            end
        end else begin
            instruction_r <= FILL;
            instr_valid_r <= 1'b0;
            pc_oob_r      <= 1'b0;
        end
    end

    assign load_ready  = load_ready_r;
    assign running     = running_r;
    assign prog_len    = prog_len_r;
    assign instruction = instruction_r;
    assign instr_valid = instr_valid_r;
    assign pc_oob      = pc_oob_r;

endmodule

// File: tb/tb_program_memory_loader.sv
// Scoreboard bench: fetch expectations are queued by the stimulus and popped
// by per-instance monitors whenever instr_valid is presented.
module tb_program_memory_loader;

    typedef struct packed {
        logic [7:0] instr;
        logic       oob;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    // Main instance: DEPTH 64, non-zero fill word
    logic       load_valid = 1'b0, load_last = 1'b0, run_start = 1'b0, run_stop = 1'b0;
    logic [7:0] load_data = 8'h00, pc = 8'h00;
    logic       load_ready, instr_valid, pc_oob, running;
    logic [7:0] instruction;
    logic [6:0] prog_len;

    // Small instance: DEPTH 4, default fill word
    logic       d4_load_valid = 1'b0, d4_load_last = 1'b0, d4_run_start = 1'b0, d4_run_stop = 1'b0;
    logic [7:0] d4_load_data = 8'h00, d4_pc = 8'h00;
    logic       d4_load_ready, d4_instr_valid, d4_pc_oob, d4_running;
    logic [7:0] d4_instruction;
    logic [2:0] d4_prog_len;

    exp_t exp_q[$];
    exp_t exp4_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    program_memory_loader #(.IW(8), .DEPTH(64), .PCW(8), .FILL(8'hEE)) u_dut (
        .origclk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .load_last(load_last), .run_start(run_start), .run_stop(run_stop),
        .pc(pc), .instruction(instruction), .instr_valid(instr_valid),
        .pc_oob(pc_oob), .prog_len(prog_len), .running(running)
    );

    program_memory_loader #(.IW(8), .DEPTH(4), .PCW(8)) u_dut4 (
        .origclk(clk), .reset(reset),
        .load_valid(d4_load_valid), .load_ready(d4_load_ready), .load_data(d4_load_data),
        .load_last(d4_load_last), .run_start(d4_run_start), .run_stop(d4_run_stop),
        .pc(d4_pc), .instruction(d4_instruction), .instr_valid(d4_instr_valid),
        .pc_oob(d4_pc_oob), .prog_len(d4_prog_len), .running(d4_running)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic run();
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
    endtask

    task automatic fetch(input logic [7:0] p, input logic [7:0] ei, input logic eo);
        pc = p;
        exp_q.push_back(exp_t'{ei, eo});
        tick();
    endtask

    task automatic stop(input logic [7:0] ei, input logic eo);
        run_stop = 1'b1;
        exp_q.push_back(exp_t'{ei, eo});
        tick();
        run_stop = 1'b0;
    endtask

    task automatic d4_fetch(input logic [7:0] p, input logic [7:0] ei, input logic eo);
        d4_pc = p;
        exp4_q.push_back(exp_t'{ei, eo});
        tick();
    endtask

    // Monitor for the main instance
    always @(negedge clk) begin
        if (instr_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_fetch", 32'(instruction), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("fetch_instr", 32'(instruction), 32'(e.instr));
                check("fetch_oob", 32'(pc_oob), 32'(e.oob));
            end
        end
    end

    // Monitor for the DEPTH=4 instance
    always @(negedge clk) begin
        if (d4_instr_valid === 1'b1) begin
            if (exp4_q.size() == 0) begin
                check("d4_unexpected_fetch", 32'(d4_instruction), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp4_q.pop_front();
                check("d4_fetch_instr", 32'(d4_instruction), 32'(e.instr));
                check("d4_fetch_oob", 32'(d4_pc_oob), 32'(e.oob));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_load_ready", 32'(load_ready), 32'd1);
        check("rst_prog_len", 32'(prog_len), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instruction", 32'(instruction), 32'hEE);
        check("rst_pc_oob", 32'(pc_oob), 32'd0);

        // Five-word program, back to back
        load_word(8'h44, 1'b0);
        check("load_prog_len_stale", 32'(prog_len), 32'd0);
        load_word(8'h49, 1'b0);
        load_word(8'h18, 1'b0);
        load_word(8'h89, 1'b0);
        load_word(8'hC3, 1'b1);
        check("load5_prog_len", 32'(prog_len), 32'd5);
        check("load5_ready", 32'(load_ready), 32'd1);
        run();
        check("run_entered", 32'(running), 32'd1);
        check("run_load_ready", 32'(load_ready), 32'd0);
        check("run_first_not_valid", 32'(instr_valid), 32'd0);
        fetch(8'd0, 8'h44, 1'b0);
        fetch(8'd1, 8'h49, 1'b0);
        fetch(8'd2, 8'h18, 1'b0);
        fetch(8'd3, 8'h89, 1'b0);
        fetch(8'd4, 8'hC3, 1'b0);
        fetch(8'd5, 8'hEE, 1'b1);
        fetch(8'd255, 8'hEE, 1'b1);
        fetch(8'd2, 8'h18, 1'b0);

        // Load attempt while running must be refused
        load_valid = 1'b1;
        load_data  = 8'hAA;
        check("run_refuses_load", 32'(load_ready), 32'd0);
        fetch(8'd2, 8'h18, 1'b0);
        load_valid = 1'b0;
        check("run_prog_len_kept", 32'(prog_len), 32'd5);
        fetch(8'd0, 8'h44, 1'b0);

        // Stop and start together: stop wins
        run_start = 1'b1;
        stop(8'h44, 1'b0);
        run_start = 1'b0;
        check("stop_running", 32'(running), 32'd0);
        check("stop_load_ready", 32'(load_ready), 32'd1);
        tick();
        check("stop_valid_low", 32'(instr_valid), 32'd0);
        check("stop_fill", 32'(instruction), 32'hEE);

        // Load beats run_start in READY
        load_valid = 1'b1;
        load_data  = 8'h11;
        run_start  = 1'b1;
        tick();
        load_valid = 1'b0;
        run_start  = 1'b0;
        check("loadwins_running", 32'(running), 32'd0);
        check("loadwins_prog_len", 32'(prog_len), 32'd0);
        run();
        check("start_in_load_ignored", 32'(running), 32'd0);
        load_word(8'h22, 1'b1);
        check("load2_prog_len", 32'(prog_len), 32'd2);
        run();
        fetch(8'd0, 8'h11, 1'b0);
        fetch(8'd1, 8'h22, 1'b0);
        fetch(8'd2, 8'hEE, 1'b1);
        stop(8'hEE, 1'b1);
        tick();

        // Reset in the middle of a load
        load_word(8'h33, 1'b0);
        load_word(8'h34, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midload_rst_prog_len", 32'(prog_len), 32'd0);
        check("midload_rst_ready", 32'(load_ready), 32'd1);
        run();
        check("idle_start_ignored", 32'(running), 32'd0);
        load_word(8'h55, 1'b1);
        check("load1_prog_len", 32'(prog_len), 32'd1);
        run();
        fetch(8'd0, 8'h55, 1'b0);
        fetch(8'd1, 8'hEE, 1'b1);
        fetch(8'd0, 8'h55, 1'b0);

        // Reset while running
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("runrst_valid", 32'(instr_valid), 32'd0);
        check("runrst_running", 32'(running), 32'd0);
        check("runrst_prog_len", 32'(prog_len), 32'd0);
        check("runrst_instruction", 32'(instruction), 32'hEE);

        // DEPTH=4: six words without load_last
        for (int i = 0; i < 6; i++) begin
            d4_load_valid = 1'b1;
            d4_load_data  = 8'(8'hA1 + i);
            tick();
            if (i == 3) begin
                check("d4_autoclose_len", 32'(d4_prog_len), 32'd4);
                check("d4_autoclose_ready", 32'(d4_load_ready), 32'd1);
            end
            if (i == 4) begin
                check("d4_restart_len", 32'(d4_prog_len), 32'd0);
            end
        end
        d4_load_valid = 1'b0;
        check("d4_loading_len", 32'(d4_prog_len), 32'd0);
        d4_run_start = 1'b1;
        tick();
        d4_run_start = 1'b0;
        check("d4_start_in_load", 32'(d4_running), 32'd0);
        d4_load_valid = 1'b1;
        d4_load_data  = 8'hA7;
        d4_load_last  = 1'b1;
        tick();
        d4_load_valid = 1'b0;
        d4_load_last  = 1'b0;
        check("d4_len3", 32'(d4_prog_len), 32'd3);
        d4_run_start = 1'b1;
        tick();
        d4_run_start = 1'b0;
        check("d4_running", 32'(d4_running), 32'd1);
        d4_fetch(8'd0, 8'hA5, 1'b0);
        d4_fetch(8'd1, 8'hA6, 1'b0);
        d4_fetch(8'd2, 8'hA7, 1'b0);
        d4_fetch(8'd3, 8'h00, 1'b1);
        d4_run_stop = 1'b1;
        exp4_q.push_back(exp_t'{8'h00, 1'b1});
        tick();
        d4_run_stop = 1'b0;
        tick();
        check("d4_stop_valid", 32'(d4_instr_valid), 32'd0);

        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("d4_scoreboard_drained", 32'(exp4_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
